// File: rtl/lc3b_types.sv
// Shared LC-3b types: L2 control FSM state encoding and L2 datapath mux selects.
package lc3b_types;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HIT_CHECK = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } l2_ctrl_state_t;

  localparam logic L2_DATAIN_ARB   = 1'b0;
  localparam logic L2_DATAIN_PMEM  = 1'b1;
  localparam logic L2_PADDR_REQ    = 1'b0;
  localparam logic L2_PADDR_VICTIM = 1'b1;

endpackage

// File: rtl/l2_perf_counter.sv
// Saturating 32-bit event counter with asynchronous active-high reset.
module l2_perf_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  output logic [31:0] count
);

  // Count events, holding at all-ones once saturated
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 32'd1;
  end

endmodule

// File: rtl/l2_cache_control.sv
// Control FSM for the unified 2-way set-associative L2 cache.
// Optional hit/miss performance counters are built when L2_PERF_CNT_EN is defined.
module l2_cache_control
  import lc3b_types::*;
#(
  parameter int unsigned HIT_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic arb_l2_mem_read,
  input  logic arb_l2_mem_write,
  output logic l2arb_mem_resp,
  input  logic hit0,
  input  logic hit1,
  input  logic dirty0,
  input  logic dirty1,
  input  logic lru_out,
  output logic pmem_read,
  output logic pmem_write,
  input  logic pmem_resp,
  output logic load_data0,
  output logic load_data1,
  output logic load_tag0,
  output logic load_tag1,
  output logic load_valid0,
  output logic load_valid1,
  output logic load_dirty0,
  output logic load_dirty1,
  output logic dirty_in,
  output logic load_lru,
  output logic lru_in,
  output logic way_sel,
  output logic datain_sel,
  output logic pmem_addr_sel
`ifdef L2_PERF_CNT_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam logic [1:0] CNT_RELOAD = 2'(HIT_LAT - 1);

  l2_ctrl_state_t state, next_state;
  logic [1:0] cnt, next_cnt;
  logic       victim, next_victim;

  logic req, hit, hit_way, victim_dirty, decide;

  assign req          = arb_l2_mem_read | arb_l2_mem_write;
  assign hit          = hit0 | hit1;
  assign hit_way      = ~hit0;                  // way 0 wins if both report a hit
  assign victim_dirty = lru_out ? dirty1 : dirty0;
  assign decide       = (state == HIT_CHECK) && req && (cnt == 2'd0);

  // State, wait counter and victim way registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      victim <= 1'b0;
    end else begin
      state  <= next_state;
      cnt    <= next_cnt;
      victim <= next_victim;
    end
  end

  // Next-state and output decode
  always_comb begin
    next_state     = state;
    next_cnt       = cnt;
    next_victim    = victim;
    l2arb_mem_resp = 1'b0;
    pmem_read      = 1'b0;
    pmem_write     = 1'b0;
    load_data0     = 1'b0;
    load_data1     = 1'b0;
    load_tag0      = 1'b0;
    load_tag1      = 1'b0;
    load_valid0    = 1'b0;
    load_valid1    = 1'b0;
    load_dirty0    = 1'b0;
    load_dirty1    = 1'b0;
    dirty_in       = 1'b0;
    load_lru       = 1'b0;
    lru_in         = 1'b0;
    way_sel        = 1'b0;
    datain_sel     = L2_DATAIN_ARB;
    pmem_addr_sel  = L2_PADDR_REQ;

    unique case (state)
      IDLE: begin
        if (req) begin
          next_state = HIT_CHECK;
          next_cnt   = CNT_RELOAD;
        end
      end

      HIT_CHECK: begin
        if (!req) begin
          next_state = IDLE;
        end else if (cnt != 2'd0) begin
          next_cnt = cnt - 2'd1;
        end else if (hit) begin
          l2arb_mem_resp = 1'b1;
          way_sel        = hit_way;
          load_lru       = 1'b1;
          lru_in         = ~hit_way;
          if (arb_l2_mem_write) begin
            load_data0  = ~hit_way;
            load_data1  = hit_way;
            load_dirty0 = ~hit_way;
            load_dirty1 = hit_way;
            dirty_in    = 1'b1;
            datain_sel  = L2_DATAIN_ARB;
          end
          next_state = IDLE;
        end else begin
          next_victim = lru_out;
          next_state  = victim_dirty ? WRITEBACK : ALLOCATE;
        end
      end

      WRITEBACK: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = L2_PADDR_VICTIM;
        way_sel       = victim;
        if (pmem_resp) begin
          load_dirty0 = ~victim;
          load_dirty1 = victim;
          dirty_in    = 1'b0;
          next_state  = req ? ALLOCATE : IDLE;
        end
      end

      ALLOCATE: begin
        pmem_read     = 1'b1;
        pmem_addr_sel = L2_PADDR_REQ;
        if (pmem_resp) begin
          load_data0  = ~victim;
          load_data1  = victim;
          load_tag0   = ~victim;
          load_tag1   = victim;
          load_valid0 = ~victim;
          load_valid1 = victim;
          load_dirty0 = ~victim;
          load_dirty1 = victim;
          dirty_in    = 1'b0;
          datain_sel  = L2_DATAIN_PMEM;
          next_state  = req ? HIT_CHECK : IDLE;
          next_cnt    = CNT_RELOAD;
        end
      end

      default: next_state = IDLE;
    endcase
  end

`ifdef L2_PERF_CNT_EN
  logic retry;

  // Marks the HIT_CHECK pass that follows an allocate so its hit is not counted
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      retry <= 1'b0;
    else if (next_state == IDLE)
      retry <= 1'b0;
    else if ((state == ALLOCATE) && pmem_resp)
      retry <= 1'b1;
  end

  l2_perf_counter u_hit_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (decide && hit && !retry),
    .count (hit_count)
  );

  l2_perf_counter u_miss_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (decide && !hit),
    .count (miss_count)
  );
`endif

endmodule

// File: tb/tb_l2_cache_control.sv
// Self-checking bench for l2_cache_control: two instances (HIT_LAT=1 and 3)
// driven by directed and randomized transactions against a per-phase reference model.
module tb_l2_cache_control;

  typedef struct packed {
    logic resp;
    logic pmem_read;
    logic pmem_write;
    logic load_data0;
    logic load_data1;
    logic load_tag0;
    logic load_tag1;
    logic load_valid0;
    logic load_valid1;
    logic load_dirty0;
    logic load_dirty1;
    logic dirty_in;
    logic load_lru;
    logic lru_in;
    logic way_sel;
    logic datain_sel;
    logic pmem_addr_sel;
  } outs_t;

  logic clk = 1'b0;
  logic reset;
  logic rd [2];
  logic wr [2];
  logic hit0, hit1, dirty0, dirty1, lru_out, pmem_resp;
  outs_t ov [2];
`ifdef L2_PERF_CNT_EN
  logic [31:0] hc [2];
  logic [31:0] mc [2];
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_hits [2];
  logic [31:0] exp_miss [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic resp, pr, pw, ld0, ld1, lt0, lt1, lv0, lv1, ldy0, ldy1, din, llru, lin, wsel, dsel, asel;
    l2_cache_control #(.HIT_LAT((g == 0) ? 1 : 3)) dut (
      .clk              (clk),
      .reset            (reset),
      .arb_l2_mem_read  (rd[g]),
      .arb_l2_mem_write (wr[g]),
      .l2arb_mem_resp   (resp),
      .hit0             (hit0),
      .hit1             (hit1),
      .dirty0           (dirty0),
      .dirty1           (dirty1),
      .lru_out          (lru_out),
      .pmem_read        (pr),
      .pmem_write       (pw),
      .pmem_resp        (pmem_resp),
      .load_data0       (ld0),
      .load_data1       (ld1),
      .load_tag0        (lt0),
      .load_tag1        (lt1),
      .load_valid0      (lv0),
      .load_valid1      (lv1),
      .load_dirty0      (ldy0),
      .load_dirty1      (ldy1),
      .dirty_in         (din),
      .load_lru         (llru),
      .lru_in           (lin),
      .way_sel          (wsel),
      .datain_sel       (dsel),
      .pmem_addr_sel    (asel)
`ifdef L2_PERF_CNT_EN
      ,
      .hit_count        (hc[g]),
      .miss_count       (mc[g])
`endif
    );
    assign ov[g] = outs_t'({resp, pr, pw, ld0, ld1, lt0, lt1, lv0, lv1,
                            ldy0, ldy1, din, llru, lin, wsel, dsel, asel});
  end

  function automatic int lat_of(input int s);
    return (s != 0) ? 3 : 1;
  endfunction

  // Expected strobes for a hit in way hw (way 0 wins when both ways hit)
  function automatic outs_t hit_outs(input bit w, input bit h0);
    outs_t e;
    bit hw;
    hw = !h0;
    e = '0;
    e.resp     = 1'b1;
    e.way_sel  = hw;
    e.load_lru = 1'b1;
    e.lru_in   = !hw;
    if (w) begin
      e.load_data0  = !hw;
      e.load_data1  = hw;
      e.load_dirty0 = !hw;
      e.load_dirty1 = hw;
      e.dirty_in    = 1'b1;
    end
    return e;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Compare the active instance against expectation; the other must sit idle
  task automatic chk(input int s, input outs_t e, input string tag);
    #1;
    checks++;
    assert (ov[s] === e) else begin
      errors++;
      $error("FAIL %s dut%0d: observed=%h expected=%h", tag, s, ov[s], e);
    end
    checks++;
    assert (ov[1-s] === outs_t'(0)) else begin
      errors++;
      $error("FAIL %s_other dut%0d: observed=%h expected=%h", tag, 1-s, ov[1-s], outs_t'(0));
    end
  endtask

  task automatic run_body(input int s, input bit r, input bit w, input bit h0, input bit h1,
                          input bit lru, input bit dy0, input bit dy1,
                          input int dwb, input int dal, input int dph, input int dk);
    int lat;
    bit req, vic;
    outs_t e;
    lat = lat_of(s);
    req = 1'b1;
    rd[s] = r; wr[s] = w;
    hit0 = h0; hit1 = h1; dirty0 = dy0; dirty1 = dy1; lru_out = lru; pmem_resp = 1'b0;
    chk(s, '0, "idle_req");
    tick();
    for (int i = 0; i < lat; i++) begin
      if (dph == 1 && dk == i) begin rd[s] = 1'b0; wr[s] = 1'b0; req = 1'b0; end
      e = '0;
      if (req && i == lat - 1 && (h0 || h1)) e = hit_outs(w, h0);
      chk(s, e, "hit_check");
      tick();
      if (!req) return;
    end
    if (h0 || h1) begin
      exp_hits[s] = exp_hits[s] + 32'd1;
      return;
    end
    exp_miss[s] = exp_miss[s] + 32'd1;
    vic = lru;
    if (vic ? dy1 : dy0) begin
      for (int i = 0; i < dwb; i++) begin
        if (dph == 2 && dk == i) begin rd[s] = 1'b0; wr[s] = 1'b0; req = 1'b0; end
        pmem_resp = (i == dwb - 1);
        e = '0;
        e.pmem_write    = 1'b1;
        e.pmem_addr_sel = 1'b1;
        e.way_sel       = vic;
        if (i == dwb - 1) begin e.load_dirty0 = !vic; e.load_dirty1 = vic; end
        chk(s, e, "writeback");
        tick();
      end
      pmem_resp = 1'b0;
      if (!req) return;
    end
    for (int i = 0; i < dal; i++) begin
      if (dph == 3 && dk == i) begin rd[s] = 1'b0; wr[s] = 1'b0; req = 1'b0; end
      pmem_resp = (i == dal - 1);
      e = '0;
      e.pmem_read = 1'b1;
      if (i == dal - 1) begin
        e.load_data0 = !vic; e.load_data1 = vic;
        e.load_tag0 = !vic; e.load_tag1 = vic;
        e.load_valid0 = !vic; e.load_valid1 = vic;
        e.load_dirty0 = !vic; e.load_dirty1 = vic;
        e.datain_sel = 1'b1;
      end
      chk(s, e, "allocate");
      tick();
    end
    pmem_resp = 1'b0;
    if (!req) return;
    // The freshly allocated line now matches in the victim way
    hit0 = !vic; hit1 = vic;
    for (int i = 0; i < lat; i++) begin
      e = (i == lat - 1) ? hit_outs(w, !vic) : outs_t'(0);
      chk(s, e, "retry");
      tick();
    end
  endtask

  task automatic txn(input int s, input bit r, input bit w, input bit h0, input bit h1,
                     input bit lru, input bit dy0, input bit dy1,
                     input int dwb, input int dal, input int dph, input int dk);
    run_body(s, r, w, h0, h1, lru, dy0, dy1, dwb, dal, dph, dk);
    rd[s] = 1'b0; wr[s] = 1'b0; pmem_resp = 1'b0;
    chk(s, '0, "idle_after");
    tick();
`ifdef L2_PERF_CNT_EN
    checks++;
    assert (hc[s] === exp_hits[s]) else begin
      errors++;
      $error("FAIL hit_count dut%0d: observed=%0d expected=%0d", s, hc[s], exp_hits[s]);
    end
    checks++;
    assert (mc[s] === exp_miss[s]) else begin
      errors++;
      $error("FAIL miss_count dut%0d: observed=%0d expected=%0d", s, mc[s], exp_miss[s]);
    end
`endif
  endtask

  initial begin
    outs_t e;
    int s, rw, hs, dph, dk;
    reset = 1'b1;
    rd[0] = 1'b0; rd[1] = 1'b0; wr[0] = 1'b0; wr[1] = 1'b0;
    hit0 = 1'b0; hit1 = 1'b0; dirty0 = 1'b0; dirty1 = 1'b0; lru_out = 1'b0; pmem_resp = 1'b0;
    exp_hits[0] = '0; exp_hits[1] = '0; exp_miss[0] = '0; exp_miss[1] = '0;
    chk(0, '0, "in_reset");
    tick();
    tick();
    reset = 1'b0;
    chk(0, '0, "after_reset");
    chk(1, '0, "after_reset");
    tick();

    // Directed cases on HIT_LAT=1
    txn(0, 1, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0);   // read hit way 1
    txn(0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0);   // write hit way 0
    txn(0, 1, 0, 0, 0, 1, 0, 0, 1, 5, 0, 0);   // clean miss, victim 1, 5-cycle fill
    txn(0, 1, 0, 0, 0, 0, 1, 0, 3, 2, 0, 0);   // dirty miss, victim 0
    txn(0, 1, 0, 0, 0, 1, 0, 0, 1, 4, 3, 1);   // request drops in ALLOCATE
    txn(0, 1, 1, 1, 1, 0, 0, 0, 1, 1, 0, 0);   // read+write, both ways hit
    txn(0, 0, 1, 0, 0, 1, 1, 1, 2, 2, 2, 0);   // request drops in WRITEBACK
    txn(0, 1, 0, 1, 0, 0, 0, 0, 1, 1, 1, 0);   // request drops in HIT_CHECK

    // Reset during WRITEBACK must drop pmem_write without waiting for a clock
    rd[0] = 1'b1; hit0 = 1'b0; hit1 = 1'b0; lru_out = 1'b0; dirty0 = 1'b1; dirty1 = 1'b0;
    chk(0, '0, "rst_idle");
    tick();
    chk(0, '0, "rst_decide");
    tick();
    e = '0; e.pmem_write = 1'b1; e.pmem_addr_sel = 1'b1;
    chk(0, e, "rst_wb");
    reset = 1'b1;
    chk(0, '0, "rst_async");
    exp_hits[0] = '0; exp_hits[1] = '0; exp_miss[0] = '0; exp_miss[1] = '0;
    tick();
    reset = 1'b0; rd[0] = 1'b0;
    chk(0, '0, "rst_release");
    tick();

    // HIT_LAT=3: four hits and two misses
    txn(1, 1, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    txn(1, 0, 1, 0, 1, 0, 0, 0, 1, 1, 0, 0);
    txn(1, 1, 0, 0, 0, 1, 0, 1, 2, 3, 0, 0);
    txn(1, 1, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0);
    txn(1, 0, 1, 0, 0, 0, 0, 0, 1, 2, 0, 0);
    txn(1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0);
`ifdef L2_PERF_CNT_EN
    checks++;
    assert (hc[1] === 32'd4 && mc[1] === 32'd2) else begin
      errors++;
      $error("FAIL perf_4_2: observed=%0d/%0d expected=4/2", hc[1], mc[1]);
    end
`endif

    // Randomized transactions on both instances
    for (int n = 0; n < 80; n++) begin
      s   = int'($urandom_range(0, 1));
      rw  = int'($urandom_range(1, 3));
      hs  = int'($urandom_range(0, 3));
      dph = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      dk  = (dph == 1) ? int'($urandom_range(0, lat_of(s) - 1)) : int'($urandom_range(0, 4));
      txn(s, rw[0], rw[1], hs[0], hs[1], 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          int'($urandom_range(1, 5)), int'($urandom_range(1, 5)), dph, dk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/l2_cache_control.md
Name: l2_cache_control

Overview:
- Control FSM for the unified 2-way set-associative L2 cache.
- Responder on the arbiter-to-L2 interface: accepts one read or write from the I/D arbiter and returns a single-cycle l2arb_mem_resp.
- Initiator toward physical memory: performs dirty-victim writeback and line allocation.
- Drives load and select strobes of the L2 datapath (tag, valid, dirty, LRU and data arrays); consumes the datapath's hit and dirty status.

Parameters:
- HIT_LAT, 1: cycles spent in HIT_CHECK before the hit/miss decision (array read latency); legal range 1..4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- arb_l2_mem_read  in  1  read request from the arbiter; held until resp.
- arb_l2_mem_write  in  1  write request from the arbiter; held until resp.
- l2arb_mem_resp  out  1  one-cycle completion pulse to the arbiter.
- hit0, hit1  in  1  way-0 and way-1 tag match AND valid for the current address.
- dirty0, dirty1  in  1  dirty bit of each way at the current index.
- lru_out  in  1  LRU way at the current index (0 or 1).
- pmem_read, pmem_write  out  1  physical-memory request strobes; held until pmem_resp.
- pmem_resp  in  1  physical-memory completion, one cycle.
- load_data0, load_data1, load_tag0, load_tag1, load_valid0, load_valid1, load_dirty0, load_dirty1  out  1  array write enables per way.
- dirty_in  out  1  value written to the dirty array.
- load_lru, lru_in  out  1  LRU write enable and LRU write value.
- way_sel  out  1  way driving the read-data/writeback mux.
- datain_sel  out  1  data-array write source: 0 = arbiter write line, 1 = pmem line.
- pmem_addr_sel  out  1  pmem address source: 0 = request address, 1 = {victim tag, index}.

Behaviour:
- States: IDLE, HIT_CHECK, WRITEBACK, ALLOCATE.
- Registered: state, wait counter (2 bits), victim (1 bit). Every output is a combinational decode of these and the inputs.
- Reset: state=IDLE, counter=0, victim=0. All outputs are 0 during and directly after reset.
- IDLE: all outputs 0. When read or write is asserted, go to HIT_CHECK and load counter = HIT_LAT-1.
- HIT_CHECK: while counter != 0, decrement it; no outputs. When counter == 0:
  - Hit: pulse l2arb_mem_resp; way_sel=hit1; load_lru=1, lru_in = ~hit_way. On a write, also load_data[hit_way]=1, datain_sel=0, load_dirty[hit_way]=1, dirty_in=1. Go to IDLE.
  - Miss: latch victim=lru_out. Go to WRITEBACK if dirty[lru_out], else go to ALLOCATE.
- WRITEBACK: pmem_write=1, pmem_addr_sel=1, way_sel=victim. On pmem_resp: load_dirty[victim]=1, dirty_in=0, then go to ALLOCATE.
- ALLOCATE: pmem_read=1, pmem_addr_sel=0. On pmem_resp: load_data, load_tag, load_valid and load_dirty of [victim] =1, datain_sel=1, dirty_in=0; go to HIT_CHECK with counter reloaded. The retry then hits.
- Latency:
  - Clean hit: resp in cycle 1+HIT_LAT after the request is first seen in IDLE.
  - Clean miss: adds one pmem transaction plus one more HIT_CHECK pass.
  - Dirty miss: adds two pmem transactions plus one more HIT_CHECK pass.
- Boundary cases:
  - Read and write both asserted: handled as a write.
  - hit0 and hit1 both set (illegal): way 0 wins.
  - Request drops in HIT_CHECK: return to IDLE with no resp and no array writes.
  - Request drops in WRITEBACK/ALLOCATE: the pmem transaction always completes (strobes held until pmem_resp); then go to IDLE and skip the retry.
  - l2arb_mem_resp is never asserted for two consecutive cycles.
  - Reset asserted mid-transaction: immediate IDLE; pmem strobes drop asynchronously.

Optional Feature:
- Macro L2_PERF_CNT_EN.
- Defined: adds outputs hit_count[31:0] and miss_count[31:0].
  - hit_count increments on each first-pass hit (a retry after allocate is not counted).
  - miss_count increments on each HIT_CHECK miss decision.
  - Both saturate at 32'hFFFFFFFF and reset asynchronously to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Add to package lc3b_types:
  - enum l2_ctrl_state_t {IDLE, HIT_CHECK, WRITEBACK, ALLOCATE}
  - constants L2_DATAIN_ARB=0, L2_DATAIN_PMEM=1, L2_PADDR_REQ=0, L2_PADDR_VICTIM=1
- One sub-module, l2_perf_counter (saturating 32-bit counter, async reset), instanced twice under L2_PERF_CNT_EN.

Test Plan:
- HIT_LAT=1; read with hit1=1 -> resp in cycle 2 after the request; way_sel=1, load_lru=1, lru_in=0; no pmem activity.
- Write with hit0=1 -> resp pulse together with load_data0=1, load_dirty0=1, dirty_in=1, datain_sel=0, lru_in=1.
- Read miss, lru_out=1, dirty1=0 -> pmem_read held 5 cycles until pmem_resp; load_tag1/valid1/data1=1, datain_sel=1; retry with hit1=1 -> resp.
- Read miss, lru_out=0, dirty0=1 -> pmem_write with pmem_addr_sel=1, then pmem_read; load_dirty0 with dirty_in=0; exactly one resp.
- Request drops during ALLOCATE -> pmem_read held until pmem_resp; then IDLE with no resp. Reset asserted in WRITEBACK -> pmem_write=0 in the same cycle.
- HIT_LAT=3 with L2_PERF_CNT_EN; 4 hits and 2 misses -> each hit resp at cycle 4; hit_count=4, miss_count=2.
